spread_matrix_axi: RTL

- Upstream feeder for the pivot-selection stage.
- Collects one frame of N_STOCKS unsigned prices from the market-data stream, latches them, then streams the full N_STOCKS x N_STOCKS signed spread matrix.
- The matrix is emitted as one contiguous valid burst, in the order the pivot stage scans: row index i inner, column index j outer.
- Entry (i,j) is price[i] - price[j], saturated to WIDTH bits.

---
 rtl/spread_matrix_axi_pkg.sv | 13 +
 rtl/spread_matrix_axi_sat_sub.sv | 31 +++
 rtl/spread_matrix_axi.sv | 107 ++++++++++
 3 files changed

// File: rtl/spread_matrix_axi_pkg.sv
// Shared types and defaults for the spread-matrix feeder.
package vyapaar_pkg;

    typedef enum logic [1:0] {LOAD, EMIT, DRAIN} state_t;

    localparam int N_STOCKS_DEF    = 4;
    localparam int PRICE_WIDTH_DEF = 16;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/spread_matrix_axi_sat_sub.sv
// Signed difference of two unsigned operands, saturated into OUT_W bits.
module sat_sub #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]         a,
    input  logic [IN_W-1:0]         b,
    output logic signed [OUT_W-1:0] diff
);

    logic signed [IN_W:0] w_d;

    // Zero-extended operands cannot overflow IN_W+1 signed bits.
    assign w_d = $signed({1'b0, a}) - $signed({1'b0, b});

    generate
        if (IN_W + 1 <= OUT_W) begin : g_ext
            assign diff = OUT_W'(w_d);
        end else begin : g_sat
            logic w_ovf;
            // Out of range whenever the bits above the result sign disagree with it.
            assign w_ovf = (w_d[IN_W:OUT_W-1] != {(IN_W-OUT_W+2){w_d[IN_W]}});
            always_comb begin
                diff = w_d[OUT_W-1:0];
                if (w_ovf)
                    diff = w_d[IN_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    endgenerate

endmodule

// File: rtl/spread_matrix_axi.sv
// Latches one frame of prices, then streams price[i]-price[j] with i inner, j outer.
module spread_matrix_axi
    import vyapaar_pkg::*;
#(
    parameter int PRICE_WIDTH = PRICE_WIDTH_DEF,
    parameter int WIDTH       = 16,
    parameter int N_STOCKS    = N_STOCKS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   axiiv,
    input  logic [PRICE_WIDTH-1:0] axiid,
    output logic                   axiir,
    output logic                   axiov,
    output logic [WIDTH-1:0]       axiod,
    output logic                   axiolast
);

    localparam int             IW   = idx_w(N_STOCKS);
    localparam logic [IW-1:0]  LAST = IW'(N_STOCKS - 1);

    state_t                 r_state, w_next;
    logic [IW-1:0]          r_load, r_i, r_j;
    logic [PRICE_WIDTH-1:0] r_price [N_STOCKS];
    logic                   r_axiir, r_axiov, r_axiolast;
    logic [WIDTH-1:0]       r_axiod;

    logic                   w_acc, w_last_ij;
    logic signed [WIDTH-1:0] w_sat;

    assign w_acc     = axiiv && r_axiir && (r_state == LOAD);
    assign w_last_ij = (r_i == LAST) && (r_j == LAST);

    sat_sub #(.IN_W(PRICE_WIDTH), .OUT_W(WIDTH)) u_sat (
        .a    (r_price[r_i]),
        .b    (r_price[r_j]),
        .diff (w_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= LOAD;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOAD:    if (w_acc && r_load == LAST) w_next = EMIT;
            EMIT:    if (w_last_ij)               w_next = DRAIN;
            DRAIN:                                w_next = LOAD;
            default:                              w_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load     <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_axiir    <= 1'b1;
            r_axiov    <= 1'b0;
            r_axiod    <= '0;
            r_axiolast <= 1'b0;
            for (int k = 0; k < N_STOCKS; k++) r_price[k] <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_acc) begin
                        r_price[r_load] <= axiid;
                        if (r_load == LAST) begin
                            r_load  <= '0;
                            r_i     <= '0;
                            r_j     <= '0;
                            r_axiir <= 1'b0;
                        end else begin
                            r_load <= r_load + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    r_axiov    <= 1'b1;
                    r_axiod    <= w_sat;
                    r_axiolast <= w_last_ij;
                    // Explicit wrap keeps non-power-of-two N_STOCKS correct.
                    if (r_i == LAST) begin
                        r_i <= '0;
                        r_j <= (r_j == LAST) ? '0 : r_j + 1'b1;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                DRAIN: begin
                    r_axiov    <= 1'b0;
                    r_axiolast <= 1'b0;
                    r_axiir    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign axiir    = r_axiir;
    assign axiov    = r_axiov;
    assign axiod    = r_axiod;
    assign axiolast = r_axiolast;

endmodule
